// File: rtl/commit_trace_streamer.sv
// Writeback commit tracer: buffers one 104-bit record per retired instruction
// and streams each record as a 14-byte SYNC-framed sequence over valid/ready.
module commit_trace_streamer #(
  parameter int unsigned DEPTH_LOG2 = 4,
  parameter logic [7:0]  SYNC_BYTE  = 8'hA5,
  parameter int unsigned DROP_W     = 16
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                trace_en,
  input  logic                wb_valid,
  input  logic [31:0]         wb_pc,
  input  logic [31:0]         wb_inst,
  input  logic                wb_we,
  input  logic [4:0]          wb_waddr,
  input  logic [31:0]         wb_wdata,
  input  logic                drop_clr,
  output logic                out_valid,
  output logic [7:0]          out_data,
  input  logic                out_ready,
  output logic [DEPTH_LOG2:0] fifo_count,
  output logic [DROP_W-1:0]   drop_count,
  output logic                overflow
);

  localparam int unsigned DEPTH = 2 ** DEPTH_LOG2;
  localparam int unsigned CW    = DEPTH_LOG2 + 1;
  localparam int unsigned REC_W = 104;
  localparam logic [3:0]  LAST_IDX = 4'd13;
  localparam logic [CW-1:0] CNT_FULL = CW'(DEPTH);

  typedef enum logic {
    S_IDLE,
    S_SEND
  } state_e;

  // FIFO storage and bookkeeping
  logic [REC_W-1:0]      mem_q [DEPTH];
  logic [DEPTH_LOG2-1:0] wr_ptr_q, wr_ptr_d;
  logic [DEPTH_LOG2-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]         count_q, count_d;
  logic                  full, empty;
  logic                  push, pop, drop;
  logic [REC_W-1:0]      wr_rec;
  logic [REC_W-1:0]      rd_rec;

  // Serializer
  state_e                state_q, state_d;
  logic [REC_W-1:0]      shift_q, shift_d;
  logic [3:0]            idx_q, idx_d;
  logic                  valid_q, valid_d;
  logic [7:0]            data_q, data_d;

  // Drop accounting
  logic [DROP_W-1:0]     drop_q, drop_d;
  logic                  ovf_q, ovf_d;

  assign wr_rec = {wb_pc, wb_inst, wb_wdata, wb_we, 2'b00, wb_waddr};
  assign rd_rec = mem_q[rd_ptr_q];
  assign full   = (count_q == CNT_FULL);
  assign empty  = (count_q == '0);

  // A full FIFO still accepts a record on the cycle the serializer frees a slot.
  assign push = wb_valid && trace_en && (!full || pop);
  assign drop = wb_valid && trace_en && !push;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push) wr_ptr_d = wr_ptr_q + DEPTH_LOG2'(1);
    if (pop)  rd_ptr_d = rd_ptr_q + DEPTH_LOG2'(1);
    unique case ({push, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= wr_rec;
  end

  always_comb begin
    state_d = state_q;
    shift_d = shift_q;
    idx_d   = idx_q;
    valid_d = valid_q;
    data_d  = data_q;
    pop     = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (!empty) begin
          pop     = 1'b1;
          shift_d = rd_rec;
          valid_d = 1'b1;
          data_d  = SYNC_BYTE;
          idx_d   = '0;
          state_d = S_SEND;
        end
      end
      S_SEND: begin
        if (valid_q && out_ready) begin
          if (idx_q != LAST_IDX) begin
            idx_d   = idx_q + 4'd1;
            data_d  = shift_q[REC_W-1 -: 8];
            shift_d = {shift_q[REC_W-9:0], 8'h00};
          end else if (!empty) begin
            // Chain straight into the next frame with no idle cycle.
            pop     = 1'b1;
            shift_d = rd_rec;
            data_d  = SYNC_BYTE;
            idx_d   = '0;
          end else begin
            valid_d = 1'b0;
            state_d = S_IDLE;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    drop_d = drop_q;
    ovf_d  = ovf_q;
    if (drop) begin
      ovf_d = 1'b1;
      if (drop_clr)           drop_d = DROP_W'(1);
      else if (drop_q != '1)  drop_d = drop_q + DROP_W'(1);
    end else if (drop_clr) begin
      drop_d = '0;
      ovf_d  = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      state_q  <= S_IDLE;
      shift_q  <= '0;
      idx_q    <= '0;
      valid_q  <= 1'b0;
      data_q   <= '0;
      drop_q   <= '0;
      ovf_q    <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      state_q  <= state_d;
      shift_q  <= shift_d;
      idx_q    <= idx_d;
      valid_q  <= valid_d;
      data_q   <= data_d;
      drop_q   <= drop_d;
      ovf_q    <= ovf_d;
    end
  end

  assign out_valid  = valid_q;
  assign out_data   = data_q;
  assign fifo_count = count_q;
  assign drop_count = drop_q;
  assign overflow   = ovf_q;

endmodule

// File: tb/tb_commit_trace_streamer.sv
// Directed bench for commit_trace_streamer: framing, backpressure, overflow,
// drop-clear race, reset mid-frame and back-to-back frames.
module tb_commit_trace_streamer;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        trace_en = 1'b0;
  logic        wb_valid = 1'b0;
  logic [31:0] wb_pc = '0;
  logic [31:0] wb_inst = '0;
  logic        wb_we = 1'b0;
  logic [4:0]  wb_waddr = '0;
  logic [31:0] wb_wdata = '0;
  logic        drop_clr = 1'b0;
  logic        out_valid;
  logic [7:0]  out_data;
  logic        out_ready = 1'b0;
  logic [4:0]  fifo_count;
  logic [15:0] drop_count;
  logic        overflow;

  int checks = 0;
  int errors = 0;
  logic [7:0] got[$];

  always #5 clk = ~clk;

  commit_trace_streamer #(.DEPTH_LOG2(4), .SYNC_BYTE(8'hA5), .DROP_W(16)) dut (
    .clk(clk), .rst(rst), .trace_en(trace_en), .wb_valid(wb_valid),
    .wb_pc(wb_pc), .wb_inst(wb_inst), .wb_we(wb_we), .wb_waddr(wb_waddr),
    .wb_wdata(wb_wdata), .drop_clr(drop_clr), .out_valid(out_valid),
    .out_data(out_data), .out_ready(out_ready), .fifo_count(fifo_count),
    .drop_count(drop_count), .overflow(overflow)
  );

  typedef struct {
    logic        en;
    logic        valid;
    logic        clr;
    logic [4:0]  exp_cnt;
    logic [15:0] exp_drop;
    logic        exp_ovf;
    logic        exp_ov;
  } vec_t;

  vec_t vecs[25];

  logic [7:0] exp_a[14] = '{8'hA5, 8'h00, 8'h00, 8'h00, 8'h04, 8'h34, 8'h01,
                            8'h11, 8'h00, 8'h00, 8'h00, 8'h11, 8'h00, 8'h81};
  logic [7:0] exp_b[14] = '{8'hA5, 8'h00, 8'h00, 8'h00, 8'h08, 8'h00, 8'h00,
                            8'h00, 8'h00, 8'hDE, 8'hAD, 8'hBE, 8'hEF, 8'h03};

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got=%0h want=%0h", name, act, exp);
    end
  endtask

  task automatic set_rec(input logic [31:0] pc, input logic [31:0] inst, input logic we,
                         input logic [4:0] wa, input logic [31:0] wd);
    wb_pc = pc; wb_inst = inst; wb_we = we; wb_waddr = wa; wb_wdata = wd;
  endtask

  task automatic rec_a(); set_rec(32'h00000004, 32'h34011100, 1'b1, 5'd1, 32'h00001100); endtask
  task automatic rec_b(); set_rec(32'h00000008, 32'h00000000, 1'b0, 5'd3, 32'hDEADBEEF); endtask

  // mode 1: out_ready pattern 1,0,0,1 repeating; inject_at >= 0 pulses wb_valid
  // on the cycle the byte with that stream index is being accepted.
  task automatic run_stream(input int nbytes, input int mode, input int inject_at,
                            output int gaps, output int unstable);
    int cyc;
    logic pv, pr;
    logic [7:0] pd;
    bit started, inj;
    cyc = 0; pv = 1'b0; pr = 1'b0; pd = '0; started = 0;
    gaps = 0; unstable = 0;
    got.delete();
    while (got.size() < nbytes && cyc < 3000) begin
      out_ready = (mode == 1) ? ((cyc % 4 == 0) || (cyc % 4 == 3)) : 1'b1;
      if (pv && !pr && (!out_valid || out_data !== pd)) unstable++;
      if (out_valid) started = 1;
      else if (started) gaps++;
      inj = (inject_at >= 0) && (got.size() == inject_at) && out_valid && out_ready;
      wb_valid = inj;
      if (out_valid && out_ready) got.push_back(out_data);
      pv = out_valid; pr = out_ready; pd = out_data;
      tick();
      cyc++;
      if (inj) begin
        chk("push_on_pop_count", fifo_count, 16);
        chk("push_on_pop_nodrop", drop_count, 0);
      end
    end
    wb_valid = 1'b0;
    out_ready = 1'b0;
    chk("stream_len", got.size(), nbytes);
  endtask

  initial begin
    int gaps, unstable;
    for (int i = 0; i < 20; i++) begin
      vecs[i].en = 1'b1; vecs[i].valid = 1'b1; vecs[i].clr = 1'b0;
      vecs[i].exp_cnt  = (i == 0) ? 5'd1 : ((i > 16) ? 5'd16 : 5'(i));
      vecs[i].exp_drop = (i >= 17) ? 16'(i - 16) : 16'd0;
      vecs[i].exp_ovf  = (i >= 17);
      vecs[i].exp_ov   = (i >= 1);
    end
    vecs[20] = '{1'b1, 1'b1, 1'b0, 5'd16, 16'd4, 1'b1, 1'b1};
    vecs[21] = '{1'b1, 1'b1, 1'b0, 5'd16, 16'd5, 1'b1, 1'b1};
    vecs[22] = '{1'b1, 1'b1, 1'b1, 5'd16, 16'd1, 1'b1, 1'b1};
    vecs[23] = '{1'b1, 1'b0, 1'b1, 5'd16, 16'd0, 1'b0, 1'b1};
    vecs[24] = '{1'b0, 1'b1, 1'b0, 5'd16, 16'd0, 1'b0, 1'b1};

    rst = 1'b1;
    tick(); tick();
    rst = 1'b0;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_data", out_data, 0);
    chk("rst_fifo_count", fifo_count, 0);
    chk("rst_drop_count", drop_count, 0);
    chk("rst_overflow", overflow, 0);

    // T1 single record, latency and byte order
    trace_en = 1'b1;
    rec_a(); wb_valid = 1'b1;
    tick();
    wb_valid = 1'b0;
    chk("t1_valid_k", out_valid, 0);
    chk("t1_count_k", fifo_count, 1);
    tick();
    chk("t1_valid_k1", out_valid, 1);
    chk("t1_sync_k1", out_data, 8'hA5);
    chk("t1_count_k1", fifo_count, 0);
    run_stream(14, 0, -1, gaps, unstable);
    for (int i = 0; i < 14 && i < got.size(); i++)
      chk($sformatf("t1_byte%0d", i), got[i], exp_a[i]);
    chk("t1_idle_after", out_valid, 0);

    // T2 backpressure
    rec_a(); wb_valid = 1'b1;
    tick();
    wb_valid = 1'b0;
    tick();
    run_stream(14, 1, -1, gaps, unstable);
    for (int i = 0; i < 14 && i < got.size(); i++)
      chk($sformatf("t2_byte%0d", i), got[i], exp_a[i]);
    chk("t2_stable", unstable, 0);

    // T6 back-to-back frames
    rec_a(); wb_valid = 1'b1;
    tick();
    rec_b();
    tick();
    wb_valid = 1'b0;
    chk("t6_valid", out_valid, 1);
    chk("t6_count", fifo_count, 1);
    run_stream(28, 0, -1, gaps, unstable);
    for (int i = 0; i < 28 && i < got.size(); i++)
      chk($sformatf("t6_byte%0d", i), got[i], (i < 14) ? exp_a[i] : exp_b[i-14]);
    chk("t6_gaps", gaps, 0);

    // T3/T4 overflow and drop-clear race, out_ready held low
    out_ready = 1'b0;
    for (int i = 0; i < 25; i++) begin
      trace_en = vecs[i].en;
      wb_valid = vecs[i].valid;
      drop_clr = vecs[i].clr;
      set_rec(32'(4 * i), 32'h10000000 + 32'(i), 1'b1, 5'(i), 32'(i));
      tick();
      chk($sformatf("v%0d_count", i), fifo_count, vecs[i].exp_cnt);
      chk($sformatf("v%0d_drop", i), drop_count, vecs[i].exp_drop);
      chk($sformatf("v%0d_ovf", i), overflow, vecs[i].exp_ovf);
      chk($sformatf("v%0d_outv", i), out_valid, vecs[i].exp_ov);
      if (vecs[i].exp_ov) chk($sformatf("v%0d_hold", i), out_data, 8'hA5);
    end
    wb_valid = 1'b0;
    drop_clr = 1'b0;

    // Drain with a push landing on the pop edge while full
    trace_en = 1'b1;
    set_rec(32'h00000100, 32'h0, 1'b0, 5'd0, 32'h0);
    run_stream(18 * 14, 0, 13, gaps, unstable);
    for (int f = 0; f < 18 && (f * 14 + 4) < got.size(); f++) begin
      chk($sformatf("drain_sync%0d", f), got[f*14], 8'hA5);
      chk($sformatf("drain_pc%0d", f),
          {got[f*14+1], got[f*14+2], got[f*14+3], got[f*14+4]},
          (f < 17) ? 32'(4 * f) : 32'h00000100);
    end
    chk("drain_count", fifo_count, 0);
    chk("drain_idle", out_valid, 0);

    // T5 reset mid-frame
    rec_a(); wb_valid = 1'b1;
    tick();
    wb_valid = 1'b0;
    tick();
    out_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      if (i == 1) begin rec_b(); wb_valid = 1'b1; end
      else wb_valid = 1'b0;
      tick();
    end
    wb_valid = 1'b0;
    chk("t5_idx6_byte", out_data, 8'h01);
    chk("t5_pre_count", fifo_count, 1);
    rst = 1'b1;
    out_ready = 1'b0;
    tick();
    rst = 1'b0;
    chk("t5_rst_valid", out_valid, 0);
    chk("t5_rst_count", fifo_count, 0);
    tick(); tick();
    chk("t5_no_resume", out_valid, 0);
    rec_a(); wb_valid = 1'b1;
    tick();
    wb_valid = 1'b0;
    tick();
    chk("t5_new_valid", out_valid, 1);
    chk("t5_new_sync", out_data, 8'hA5);
    run_stream(14, 0, -1, gaps, unstable);
    for (int i = 0; i < 14 && i < got.size(); i++)
      chk($sformatf("t5_byte%0d", i), got[i], exp_a[i]);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
